// File: rtl/barret_2089_pkg.sv
// Shared constants and the round-robin pick helper for the mod-2089 arbiter slice.
// Helper is combinational; no flow control lives here.
package barret_2089_pkg;

    localparam int Q         = 2089;
    localparam int Q_SQ      = 4363921;
    localparam int DIN_W     = 23;
    localparam int DOUT_W    = 12;
    // floor(2^24 / 2089); with k=24 the quotient estimate is at most one low for any 23-bit operand
    localparam int BARRETT_K = 24;
    localparam int BARRETT_M = 8031;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of valid, scanning upward from ptr and wrapping at n-1 -> 0.
    function automatic pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr, input int n);
        pick_t p;
        int    c;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            c = (int'(ptr) + k) % n;
            if (k < n && !p.found && valid[c[2:0]]) begin
                p.found = 1'b1;
                p.idx   = c[2:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/barret_for_2089.sv
// Combinational Barrett reduction of a 23-bit operand modulo 2089.
// Zero latency; no handshake.
import barret_2089_pkg::*;

module barret_for_2089 (
    input  logic [DIN_W-1:0]  din_a,
    output logic [DOUT_W-1:0] dout_r
);

    logic [36:0] prod;
    logic [12:0] q_est;
    logic [24:0] diff;
    logic [12:0] r;

    assign prod  = 37'(din_a) * 37'(BARRETT_M);
    assign q_est = 13'(prod >> BARRETT_K);
    assign diff  = 25'(din_a) - 25'(q_est) * 25'(Q);
    // Partial remainder is below 2*Q, so one conditional subtract finishes it.
    assign r     = 13'(diff);

    assign dout_r = (r >= 13'(Q)) ? 12'(r - 13'(Q)) : 12'(r);

endmodule

// File: rtl/barret_2089_arbiter.sv
// Round-robin share of one mod-2089 reducer among N_REQ valid/ready requesters; result registered, 1-cycle latency.
// A held result (res_valid & !res_ready) stalls every requester; consume+accept reload in the same cycle.
// Define BARRET_2089_RANGE_CHECK_EN to add res_err flagging operands >= 2089^2.
import barret_2089_pkg::*;

module barret_2089_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*DIN_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DOUT_W-1:0]      res_data,
    output logic [ID_W-1:0]        res_id,
    output logic [CNT_W-1:0]       done_cnt
`ifdef BARRET_2089_RANGE_CHECK_EN
    ,
    output logic                   res_err
`endif
);

    pick_t             pick;
    logic              can_accept;
    logic              grant;
    logic              consume;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   next_ptr;
    logic [DIN_W-1:0]  operand;
    logic [DOUT_W-1:0] reduced;
    logic [DOUT_W-1:0] data_nxt;

    assign can_accept = !res_valid || res_ready;
    assign consume    = res_valid && res_ready;
    assign pick       = rr_pick(8'(req_valid), 3'(rr_ptr), N_REQ);
    assign grant      = pick.found && can_accept && !rst;
    assign win_id     = ID_W'(pick.idx);
    assign next_ptr   = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    assign operand    = req_data[int'(pick.idx) * DIN_W +: DIN_W];

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_id] = 1'b1;
        end
    end

    barret_for_2089 u_reduce (
        .din_a  (operand),
        .dout_r (reduced)
    );

`ifdef BARRET_2089_RANGE_CHECK_EN
    logic op_err;
    assign op_err = operand >= DIN_W'(Q_SQ);

    always_comb begin
        data_nxt = reduced;
        if (op_err) begin
            data_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_err <= 1'b0;
        end else if (grant) begin
            res_err <= op_err;
        end
    end
`else
    always_comb begin
        data_nxt = reduced;
    end
`endif

    // Result register: load on grant, otherwise drain when consumed; data/id keep last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            res_valid <= 1'b1;
            res_data  <= data_nxt;
            res_id    <= win_id;
            rr_ptr    <= next_ptr;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (consume && (done_cnt != {CNT_W{1'b1}})) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_barret_2089_arbiter.sv
// Directed bench for barret_2089_arbiter with a result scoreboard fed at accept time.
module tb_barret_2089_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [91:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
    logic [1:0]  res_id;
    logic [15:0] done_cnt;
`ifdef BARRET_2089_RANGE_CHECK_EN
    logic        res_err;
`endif

    barret_2089_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .done_cnt  (done_cnt)
`ifdef BARRET_2089_RANGE_CHECK_EN
        ,
        .res_err   (res_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [11:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   passed   = 0;
    int   fails    = 0;
    int   consumed = 0;
    logic [3:0] hold_mask = 4'b0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [22:0] x);
        exp_t e;
        e.id = 2'(id);
`ifdef BARRET_2089_RANGE_CHECK_EN
        e.err  = (x >= 23'd4363921);
        e.data = e.err ? 12'd0 : 12'(x % 23'd2089);
`else
        e.err  = 1'b0;
        e.data = 12'(x % 23'd2089);
`endif
        return e;
    endfunction

    task automatic set_op(input int i, input logic [22:0] v);
        req_data[23*i +: 23] = v;
    endtask

    // One clock: check grant vector, score any consumed result, queue any accepted operand.
    task automatic cycle(input logic [3:0] exp_rdy, input string tag);
        logic [3:0] acc;
        exp_t e;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check({tag, "_unexpected_res"}, 32'(res_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                consumed++;
                check({tag, "_data"}, 32'(res_data), 32'(e.data));
                check({tag, "_id"}, 32'(res_id), 32'(e.id));
`ifdef BARRET_2089_RANGE_CHECK_EN
                check({tag, "_err"}, 32'(res_err), 32'(e.err));
`endif
            end
        end
        acc = req_valid & req_ready;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) sb.push_back(model(i, req_data[23*i +: 23]));
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(acc & ~hold_mask);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = '0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        @(negedge clk);
        check("rst_rdy_gated", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);

        // Single request, then consume
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 23'd5000);
        cycle(4'b0001, "single_acc");
        check("single_res_valid", 32'(res_valid), 32'd1);
        check("single_res_data", 32'(res_data), 32'd822);
        cycle(4'b0000, "single_drain");
        check("single_done_cnt", 32'(done_cnt), 32'd1);
        check("single_res_valid_low", 32'(res_valid), 32'd0);

        // Reset while a result is pending
        req_valid = 4'b1000;
        set_op(3, 23'd7000);
        cycle(4'b1000, "mid_acc");
        rst       = 1'b1;
        res_ready = 1'b0;
        cycle(4'b0000, "mid_rst");
        check("mid_res_valid", 32'(res_valid), 32'd0);
        check("mid_done_cnt", 32'(done_cnt), 32'd0);
        check("mid_res_id", 32'(res_id), 32'd0);
        sb.delete();
        consumed  = 0;
        rst       = 1'b0;
        res_ready = 1'b1;

        // Round robin from pointer 0, back-to-back results
        set_op(0, 23'd2088);
        set_op(1, 23'd2089000);
        set_op(2, 23'd8388607);
        set_op(3, 23'd4363920);
        req_valid = 4'b1111;
        cycle(4'b0001, "rr0");
        cycle(4'b0010, "rr1");
        cycle(4'b0100, "rr2");
        cycle(4'b1000, "rr3");
        set_op(0, 23'd50);
        set_op(3, 23'd60);
        req_valid = 4'b1001;
        cycle(4'b0001, "rr_wrap");
        cycle(4'b1000, "rr_wrap3");

        // Backpressure: 822 held three cycles, grant resumes on release
        req_valid = 4'b0001;
        set_op(0, 23'd5000);
        cycle(4'b0001, "bp_acc");
        res_ready = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 23'd100);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0000, "bp_hold");
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_data", 32'(res_data), 32'd822);
        end
        res_ready = 1'b1;
        cycle(4'b0010, "bp_release");

        // Fairness: requester 2 always valid, requester 1 once
        hold_mask = 4'b0100;
        req_valid = 4'b0100;
        set_op(2, 23'd4000);
        cycle(4'b0100, "fair_a");
        req_valid = req_valid | 4'b0010;
        set_op(1, 23'd10);
        cycle(4'b0010, "fair_b");
        cycle(4'b0100, "fair_c");
        hold_mask = 4'b0000;
        req_valid = 4'b0000;
        cycle(4'b0000, "fair_drain");

`ifdef BARRET_2089_RANGE_CHECK_EN
        req_valid = 4'b0001;
        set_op(0, 23'd4363921);
        cycle(4'b0001, "range_hi");
        req_valid = 4'b0001;
        set_op(0, 23'd4363920);
        cycle(4'b0001, "range_max");
        cycle(4'b0000, "range_drain");
`endif

        check("end_res_valid", 32'(res_valid), 32'd0);
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        check("end_done_cnt", 32'(done_cnt), 32'(consumed));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
